// File: rtl/sequence_detect_controller.sv
// Run-time programmable serial sequence detector with scan control.
// Counts overlapping matches; the scan ends on the target, the bit limit or an abort.
module sequence_detect_controller #(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 8,
  parameter  int LIM_W   = 16,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic [LIM_W-1:0]   cfg_limit,
  input  logic               a_valid,
  input  logic               a,
  output logic               busy,
  output logic               detected,
  output logic               done,
  output logic               cfg_err,
  output logic [CNT_W-1:0]   match_count,
  output logic               status_hit,
  output logic               status_limit
);

  // state | meaning
  // IDLE  | waiting for start; config is sampled on an accepted start
  // SCAN  | accepting qualified bits and counting matches
  // DONE  | one-cycle done pulse after target or limit, then IDLE
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t state, state_nxt;

  logic [MAX_LEN-1:0] pat_r, pat_nxt;
  logic [LEN_W-1:0]   len_r, len_nxt;
  logic [CNT_W-1:0]   tgt_r, tgt_nxt;
  logic [LIM_W-1:0]   lim_r, lim_nxt;

  logic [MAX_LEN-1:0] hist, hist_nxt;
  logic [LEN_W-1:0]   fill, fill_nxt;
  logic [LIM_W-1:0]   bit_cnt, bit_cnt_nxt;

  logic               busy_nxt, detected_nxt, done_nxt, cfg_err_nxt;
  logic [CNT_W-1:0]   count_nxt;
  logic               hit_nxt, limit_nxt;

  logic [MAX_LEN-1:0] hist_shift, mask;
  logic [LEN_W-1:0]   fill_inc;
  logic [LIM_W-1:0]   bit_inc;
  logic [CNT_W-1:0]   cnt_inc;
  logic               len_ok, match;

  always_comb begin
    hist_shift = {hist[MAX_LEN-2:0], a};
    fill_inc   = (fill == LEN_W'(MAX_LEN)) ? fill : fill + 1'b1;
    bit_inc    = bit_cnt + 1'b1;
    cnt_inc    = (match_count == '1) ? match_count : match_count + 1'b1;
    len_ok     = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    mask       = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len_r);
    end
    // Only the low len bits of the post-shift history take part in the compare.
    match = (fill_inc >= len_r) && (((hist_shift ^ pat_r) & mask) == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pat_r        <= '0;
      len_r        <= '0;
      tgt_r        <= '0;
      lim_r        <= '0;
      hist         <= '0;
      fill         <= '0;
      bit_cnt      <= '0;
      busy         <= 1'b0;
      detected     <= 1'b0;
      done         <= 1'b0;
      cfg_err      <= 1'b0;
      match_count  <= '0;
      status_hit   <= 1'b0;
      status_limit <= 1'b0;
    end else begin
      state        <= state_nxt;
      pat_r        <= pat_nxt;
      len_r        <= len_nxt;
      tgt_r        <= tgt_nxt;
      lim_r        <= lim_nxt;
      hist         <= hist_nxt;
      fill         <= fill_nxt;
      bit_cnt      <= bit_cnt_nxt;
      busy         <= busy_nxt;
      detected     <= detected_nxt;
      done         <= done_nxt;
      cfg_err      <= cfg_err_nxt;
      match_count  <= count_nxt;
      status_hit   <= hit_nxt;
      status_limit <= limit_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pat_nxt      = pat_r;
    len_nxt      = len_r;
    tgt_nxt      = tgt_r;
    lim_nxt      = lim_r;
    hist_nxt     = hist;
    fill_nxt     = fill;
    bit_cnt_nxt  = bit_cnt;
    detected_nxt = 1'b0;
    cfg_err_nxt  = 1'b0;
    count_nxt    = match_count;
    hit_nxt      = status_hit;
    limit_nxt    = status_limit;

    unique case (state)
      IDLE: begin
        if (start) begin
          if (len_ok) begin
            pat_nxt     = cfg_pattern;
            len_nxt     = cfg_len;
            tgt_nxt     = cfg_target;
            lim_nxt     = cfg_limit;
            hist_nxt    = '0;
            fill_nxt    = '0;
            bit_cnt_nxt = '0;
            count_nxt   = '0;
            hit_nxt     = 1'b0;
            limit_nxt   = 1'b0;
            state_nxt   = SCAN;
          end else begin
            cfg_err_nxt = 1'b1;
          end
        end
      end
      SCAN: begin
        // Abort wins over a bit arriving in the same cycle; that bit is dropped.
        if (abort) begin
          state_nxt = IDLE;
        end else if (a_valid) begin
          hist_nxt    = hist_shift;
          fill_nxt    = fill_inc;
          bit_cnt_nxt = bit_inc;
          if (match) begin
            detected_nxt = 1'b1;
            count_nxt    = cnt_inc;
          end
          if (match && (tgt_r != '0) && (cnt_inc == tgt_r)) begin
            hit_nxt   = 1'b1;
            state_nxt = DONE;
          end else if ((lim_r != '0) && (bit_inc == lim_r)) begin
            limit_nxt = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt == SCAN);
    done_nxt = (state == SCAN) && (state_nxt == DONE);
  end

endmodule
